// File: rtl/fabric_cfg_sbr_pkg.sv
// Local decode enum and CRC helper for fabric_cfg_sbr.
package fabric_cfg_sbr_pkg;
  import soc_pkg::*;

  typedef enum logic [2:0] {
    RegCtrl,
    RegStatus,
    RegData,
    RegWordCnt,
    RegCrc,
    RegNone
  } reg_sel_e;

  // CRC-32 over one 32-bit word, MSB first, no reflection.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                             input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = (c << 1) ^ FabricCfgCrcPoly;
      else                 c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/soc_pkg.sv
// SoC-level OBI subordinate types plus the fabric configuration port
// register offsets and CRC constants shared by fabric_cfg_sbr.
package soc_pkg;

  localparam int unsigned ObiIdWidth = 4;

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [ObiIdWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]           rdata;
    logic [ObiIdWidth-1:0] rid;
    logic                  err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  localparam logic [31:0] FabricCfgCtrlOffset    = 32'h0000_0000;
  localparam logic [31:0] FabricCfgStatusOffset  = 32'h0000_0004;
  localparam logic [31:0] FabricCfgDataOffset    = 32'h0000_0008;
  localparam logic [31:0] FabricCfgWordCntOffset = 32'h0000_000C;
  localparam logic [31:0] FabricCfgCrcOffset     = 32'h0000_0010;

  localparam logic [31:0] FabricCfgCrcPoly = 32'h04C1_1DB7;
  localparam logic [31:0] FabricCfgCrcInit = 32'hFFFF_FFFF;

endpackage

// File: rtl/fabric_cfg_fifo.sv
// Synchronous word FIFO with flush; flush wins over a same-edge push.
module fabric_cfg_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32,
  parameter int unsigned LvlW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/fabric_cfg_sbr.sv
// OBI subordinate feeding eFPGA configuration words through a FIFO.
// Optional macro FABRIC_CFG_CRC_EN adds a CRC-32 register at offset 0x10.
module fabric_cfg_sbr
  import soc_pkg::*;
  import fabric_cfg_sbr_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter logic [31:0] AddrMask  = 32'h0000_00FF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output logic [31:0]  cfg_data_o,
  output logic         cfg_valid_o,
  input  logic         cfg_ready_i,
  output logic         busy_o
);

  localparam int unsigned LvlW = $clog2(FifoDepth) + 1;

  logic [31:0]           reg_off;
  logic                  unused_addr_lsb;
  reg_sel_e              reg_sel;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LvlW-1:0]       fifo_level;
  logic [31:0]           fifo_head;
  logic                  en_q;
  logic [31:0]           word_cnt_q;
  logic                  rvalid_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic [ObiIdWidth-1:0] rid_q;
  logic                  gnt;
  logic                  req_acc;
  logic                  push;
  logic                  flush;
  logic                  ctrl_we;
  logic                  pop;
  logic [31:0]           rdata_d;
  logic                  err_d;
  logic [7:0]            level8;
`ifdef FABRIC_CFG_CRC_EN
  logic [31:0]           crc_q;
`endif

  assign reg_off         = obi_req_i.a.addr & AddrMask;
  assign unused_addr_lsb = ^reg_off[1:0];
  assign level8          = 8'(fifo_level);

  // Word-aligned register select.
  always_comb begin
    reg_sel = RegNone;
    case ({reg_off[31:2], 2'b00})
      FabricCfgCtrlOffset:    reg_sel = RegCtrl;
      FabricCfgStatusOffset:  reg_sel = RegStatus;
      FabricCfgDataOffset:    reg_sel = RegData;
      FabricCfgWordCntOffset: reg_sel = RegWordCnt;
`ifdef FABRIC_CFG_CRC_EN
      FabricCfgCrcOffset:     reg_sel = RegCrc;
`endif
      default:                reg_sel = RegNone;
    endcase
  end

  // Grant, read data, error and register side effects of the current request.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    ctrl_we = 1'b0;
    // Full check uses registered FIFO state, so a same-cycle pop does not help.
    gnt     = obi_req_i.req &&
              !(obi_req_i.a.we && (reg_sel == RegData) && fifo_full);
    req_acc = obi_req_i.req && gnt;
    case (reg_sel)
      RegCtrl: begin
        if (obi_req_i.a.we) begin
          ctrl_we = req_acc && obi_req_i.a.be[0];
          flush   = ctrl_we && obi_req_i.a.wdata[1];
        end else begin
          rdata_d = {31'b0, en_q};
        end
      end
      RegStatus: begin
        if (obi_req_i.a.we) err_d = 1'b1;
        else rdata_d = {16'b0, level8, 5'b0, fifo_empty, fifo_full, !fifo_empty};
      end
      RegData: begin
        if (obi_req_i.a.we && (obi_req_i.a.be == 4'hF)) push = req_acc;
        else err_d = 1'b1;
      end
      RegWordCnt: begin
        if (obi_req_i.a.we) err_d = 1'b1;
        else rdata_d = word_cnt_q;
      end
`ifdef FABRIC_CFG_CRC_EN
      RegCrc: begin
        if (obi_req_i.a.we) err_d = 1'b1;
        else rdata_d = crc_q;
      end
`endif
      default: err_d = 1'b1;
    endcase
  end

  assign cfg_valid_o = en_q && !fifo_empty;
  assign cfg_data_o  = fifo_head;
  assign pop         = cfg_valid_o && cfg_ready_i;
  assign busy_o      = !fifo_empty;

  fabric_cfg_fifo #(
    .Depth (FifoDepth),
    .Width (32),
    .LvlW  (LvlW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (obi_req_i.a.wdata),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // One-cycle response pipeline; no rready so it never stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= req_acc;
      if (req_acc) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
        rid_q   <= obi_req_i.a.aid;
      end
    end
  end

  // CTRL enable and delivered-word counter (wraps naturally).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      if (ctrl_we) en_q <= obi_req_i.a.wdata[0];
      if (pop)     word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

`ifdef FABRIC_CFG_CRC_EN
  // Running CRC over delivered words; flush restarts it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    crc_q <= FabricCfgCrcInit;
    else if (flush) crc_q <= FabricCfgCrcInit;
    else if (pop)   crc_q <= crc32_word(crc_q, fifo_head);
  end
`endif

  assign obi_rsp_o.gnt     = gnt;
  assign obi_rsp_o.rvalid  = rvalid_q;
  assign obi_rsp_o.r.rdata = rdata_q;
  assign obi_rsp_o.r.err   = err_q;
  assign obi_rsp_o.r.rid   = rid_q;

endmodule

// File: tb/tb_fabric_cfg_sbr.sv
// Directed bench for fabric_cfg_sbr with response and fabric-word scoreboards.
module tb_fabric_cfg_sbr;
  import soc_pkg::*;

  localparam logic [31:0] Base = 32'h4000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } rsp_t;

  logic         clk;
  logic         rst_n;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  logic [31:0]  cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         busy;

  int          checks = 0;
  int          errors = 0;
  rsp_t        rsp_q[$];
  logic [31:0] cfg_q[$];
  logic [31:0] exp_cnt = 0;
  logic [3:0]  next_aid = 0;

  fabric_cfg_sbr #(.FifoDepth(4), .AddrMask(32'h0000_00FF)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .obi_req_i   (obi_req),
    .obi_rsp_o   (obi_rsp),
    .cfg_data_o  (cfg_data),
    .cfg_valid_o (cfg_valid),
    .cfg_ready_i (cfg_ready),
    .busy_o      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fabric-side scoreboard: each handshake must match the oldest pushed word.
  always @(negedge clk) begin
    #3;
    if (rst_n && cfg_valid && cfg_ready) begin
      if (cfg_q.size() == 0) begin
        check("cfg_unexpected_valid", {31'b0, cfg_valid}, 32'd0);
      end else begin
        check("cfg_data", cfg_data, cfg_q.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
    end
  end

  // Apply the bench's own model of register side effects at the granting edge.
  task automatic model_accept(input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
    logic [7:0] off;
    off = addr[7:0];
    if (we && off[7:2] == 6'd2 && be == 4'hF) cfg_q.push_back(wdata);
    if (we && off[7:2] == 6'd0 && be[0] && wdata[1]) cfg_q.delete();
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    check({tag, "_rvalid"}, {31'b0, obi_rsp.rvalid}, 32'd1);
    if (rsp_q.size() != 0) begin
      e = rsp_q.pop_front();
      check({tag, "_rdata"}, obi_rsp.r.rdata, e.rdata);
      check({tag, "_err"}, {31'b0, obi_rsp.r.err}, {31'b0, e.err});
      check({tag, "_rid"}, {28'b0, obi_rsp.r.rid}, {28'b0, e.rid});
    end
  endtask

  task automatic obi_xfer(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
    logic granted;
    rsp_t e;
    @(negedge clk);
    obi_req.req     = 1'b1;
    obi_req.a.addr  = addr;
    obi_req.a.we    = we;
    obi_req.a.be    = be;
    obi_req.a.wdata = wdata;
    obi_req.a.aid   = next_aid;
    granted = 1'b0;
    for (int n = 0; n < 50 && !granted; n++) begin
      #1;
      if (obi_rsp.gnt) granted = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_gnt"}, {31'b0, granted}, 32'd1);
    if (granted) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.rid   = next_aid;
      rsp_q.push_back(e);
      @(posedge clk);
      if (!exp_err) model_accept(we, addr, be, wdata);
      next_aid = next_aid + 4'd1;
      @(negedge clk);
      obi_req.req = 1'b0;
      #1;
      check_rsp(tag);
    end else begin
      obi_req.req = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    obi_req   = '0;
    cfg_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp", {31'b0, obi_rsp === '0}, 32'd1);
    check("rst_valid", {31'b0, cfg_valid}, 32'd0);
    check("rst_data", cfg_data, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    obi_xfer("rst_ctrl", 1'b0, Base + 32'h0, 4'hF, 32'd0, 32'd0, 1'b0);
    obi_xfer("rst_wcnt", 1'b0, Base + 32'hC, 4'hF, 32'd0, 32'd0, 1'b0);

    // Streaming with the fabric always ready.
    cfg_ready = 1'b1;
    obi_xfer("en", 1'b1, Base + 32'h0, 4'hF, 32'd1, 32'd0, 1'b0);
    for (int i = 1; i <= 3; i++)
      obi_xfer("data", 1'b1, Base + 32'h8, 4'hF, 32'hA5A5_0000 + i, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    obi_xfer("wcnt3", 1'b0, Base + 32'hC, 4'hF, 32'd0, 32'd3, 1'b0);
    obi_xfer("stat_empty", 1'b0, Base + 32'h4, 4'hF, 32'd0, 32'h0000_0004, 1'b0);

    // Fill with EN off, then stall a fifth write until a pop frees a slot.
    cfg_ready = 1'b0;
    obi_xfer("dis", 1'b1, Base + 32'h0, 4'hF, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      obi_xfer("fill", 1'b1, Base + 32'h8, 4'hF, 32'hB000_0000 + i, 32'd0, 1'b0);
    obi_xfer("stat_full", 1'b0, Base + 32'h4, 4'hF, 32'd0, 32'h0000_0403, 1'b0);
    @(negedge clk);
    obi_req.req     = 1'b1;
    obi_req.a.addr  = Base + 32'h8;
    obi_req.a.we    = 1'b1;
    obi_req.a.be    = 4'hF;
    obi_req.a.wdata = 32'hB000_0004;
    obi_req.a.aid   = next_aid;
    #1;
    check("stall_gnt_a", {31'b0, obi_rsp.gnt}, 32'd0);
    @(negedge clk);
    #1;
    check("stall_gnt_b", {31'b0, obi_rsp.gnt}, 32'd0);
    force dut.en_q = 1'b1;
    cfg_ready = 1'b1;
    #1;
    check("stall_pop_valid", {31'b0, cfg_valid}, 32'd1);
    check("stall_same_cycle", {31'b0, obi_rsp.gnt}, 32'd0);
    @(negedge clk);
    #1;
    check("stall_release", {31'b0, obi_rsp.gnt}, 32'd1);
    rsp_q.push_back('{rdata: 32'd0, err: 1'b0, rid: next_aid});
    @(posedge clk);
    model_accept(1'b1, Base + 32'h8, 4'hF, 32'hB000_0004);
    release dut.en_q;
    next_aid = next_aid + 4'd1;
    @(negedge clk);
    obi_req.req = 1'b0;
    #1;
    check_rsp("stall");
    repeat (8) @(negedge clk);
    #1;
    check("drain_busy", {31'b0, busy}, 32'd0);
    obi_xfer("wcnt8", 1'b0, Base + 32'hC, 4'hF, 32'd0, 32'd8, 1'b0);
    obi_xfer("dis2", 1'b1, Base + 32'h0, 4'hF, 32'd0, 32'd0, 1'b0);

    // Error decode.
    obi_xfer("rd_unmapped", 1'b0, Base + 32'h20, 4'hF, 32'd0, 32'd0, 1'b1);
    obi_xfer("wr_status", 1'b1, Base + 32'h4, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    obi_xfer("wr_data_be3", 1'b1, Base + 32'h8, 4'h3, 32'hDEAD_BEEF, 32'd0, 1'b1);
    obi_xfer("rd_data", 1'b0, Base + 32'h8, 4'hF, 32'd0, 32'd0, 1'b1);
    obi_xfer("stat_after_err", 1'b0, Base + 32'h4, 4'hF, 32'd0, 32'h0000_0004, 1'b0);

    // Flush with EN off; EN and FLUSH land together, nothing may be emitted.
    for (int i = 0; i < 3; i++)
      obi_xfer("pre_flush", 1'b1, Base + 32'h8, 4'hF, 32'hC000_0000 + i, 32'd0, 1'b0);
    obi_xfer("stat_lvl3", 1'b0, Base + 32'h4, 4'hF, 32'd0, 32'h0000_0301, 1'b0);
    obi_xfer("flush", 1'b1, Base + 32'h0, 4'hF, 32'd3, 32'd0, 1'b0);
    check("flush_valid", {31'b0, cfg_valid}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd0);
    obi_xfer("stat_flushed", 1'b0, Base + 32'h4, 4'hF, 32'd0, 32'h0000_0004, 1'b0);
    obi_xfer("ctrl_rd", 1'b0, Base + 32'h0, 4'hF, 32'd0, 32'd1, 1'b0);
    obi_xfer("ctrl_be2", 1'b1, Base + 32'h0, 4'h2, 32'd0, 32'd0, 1'b0);
    obi_xfer("ctrl_rd2", 1'b0, Base + 32'h0, 4'hF, 32'd0, 32'd1, 1'b0);

    // Counter wrap.
    @(negedge clk);
    force dut.word_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    obi_xfer("wrap_data", 1'b1, Base + 32'h8, 4'hF, 32'h0000_1234, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    obi_xfer("wcnt_wrap", 1'b0, Base + 32'hC, 4'hF, 32'd0, 32'd0, 1'b0);
    check("model_cnt_wrap", exp_cnt, dut.word_cnt_q);

`ifdef FABRIC_CFG_CRC_EN
    obi_xfer("crc_flush0", 1'b1, Base + 32'h0, 4'hF, 32'd3, 32'd0, 1'b0);
    obi_xfer("crc_data", 1'b1, Base + 32'h8, 4'hF, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    obi_xfer("crc_zero", 1'b0, Base + 32'h10, 4'hF, 32'd0, 32'hC704_DD7B, 1'b0);
    obi_xfer("crc_flush1", 1'b1, Base + 32'h0, 4'hF, 32'd3, 32'd0, 1'b0);
    obi_xfer("crc_init", 1'b0, Base + 32'h10, 4'hF, 32'd0, 32'hFFFF_FFFF, 1'b0);
`else
    obi_xfer("crc_absent", 1'b0, Base + 32'h10, 4'hF, 32'd0, 32'd0, 1'b1);
`endif

    // Reset with a response pending.
    @(negedge clk);
    obi_req.req     = 1'b1;
    obi_req.a.addr  = Base + 32'h0;
    obi_req.a.we    = 1'b0;
    obi_req.a.be    = 4'hF;
    obi_req.a.aid   = next_aid;
    @(negedge clk);
    obi_req.req = 1'b0;
    #1;
    check("pend_rvalid", {31'b0, obi_rsp.rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rsp", {31'b0, obi_rsp === '0}, 32'd1);
    check("rst_mid_valid", {31'b0, cfg_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_q.delete();
    obi_xfer("post_rst_ctrl", 1'b0, Base + 32'h0, 4'hF, 32'd0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
